// File: rtl/deconv2.sv
// deconv2: sequential stride-1 transposed convolution, one input pixel per cycle.
// Optional DECONV_RELU_EN clamps negative results to zero before saturation.
module deconv2 #(
  parameter int IN_SIZE   = 6,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8,
  parameter int SHIFT     = 0,
  localparam int OUT_SIZE = IN_SIZE + SIZEKer - 1
) (
  input  logic                                                  clock,
  input  logic                                                  nreset,
  input  logic                                                  start,
  input  logic signed [IN_SIZE-1:0][IN_SIZE-1:0][WIDTH_BIT-1:0]   inpMatrixI,
  input  logic signed [SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0]   kernel,
  output logic                                                  busy,
  output logic                                                  done,
  output logic signed [OUT_SIZE-1:0][OUT_SIZE-1:0][WIDTH_BIT-1:0] deconvOut
);

  localparam int AW = 2*WIDTH_BIT + $clog2(SIZEKer*SIZEKer);
  localparam int RW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [RW-1:0] LAST = RW'(IN_SIZE - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((2**(WIDTH_BIT-1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

  state_t state, nxt;
  logic [RW-1:0] r, c;
  logic          last;
  logic signed [WIDTH_BIT-1:0]   in_q  [IN_SIZE][IN_SIZE];
  logic signed [WIDTH_BIT-1:0]   ker_q [SIZEKer][SIZEKer];
  logic signed [AW-1:0]          acc   [OUT_SIZE][OUT_SIZE];
  logic signed [WIDTH_BIT-1:0]   pix;
  logic signed [2*WIDTH_BIT-1:0] prod  [SIZEKer][SIZEKer];

  function automatic logic [WIDTH_BIT-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] v;
    v = a >>> SHIFT;
`ifdef DECONV_RELU_EN
    if (v[AW-1]) v = '0;
`endif
    if (v > MAXV) v = MAXV;
    else if (v < MINV) v = MINV;
    return v[WIDTH_BIT-1:0];
  endfunction

  assign last = (r == LAST) && (c == LAST);

  always_comb begin
    pix = in_q[r][c];
    for (int unsigned k = 0; k < SIZEKer; k++)
      for (int unsigned l = 0; l < SIZEKer; l++)
        prod[k][l] = pix * ker_q[k][l];
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = ACCUM;
      ACCUM:   if (last) nxt = FINAL;
      FINAL:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset)
    if (!nreset) state <= IDLE;
    else         state <= nxt;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r         <= '0;
      c         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      deconvOut <= '0;
      for (int unsigned i = 0; i < IN_SIZE; i++)
        for (int unsigned j = 0; j < IN_SIZE; j++) in_q[i][j] <= '0;
      for (int unsigned k = 0; k < SIZEKer; k++)
        for (int unsigned l = 0; l < SIZEKer; l++) ker_q[k][l] <= '0;
      for (int unsigned i = 0; i < OUT_SIZE; i++)
        for (int unsigned j = 0; j < OUT_SIZE; j++) acc[i][j] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          for (int unsigned i = 0; i < IN_SIZE; i++)
            for (int unsigned j = 0; j < IN_SIZE; j++) in_q[i][j] <= inpMatrixI[i][j];
          for (int unsigned k = 0; k < SIZEKer; k++)
            for (int unsigned l = 0; l < SIZEKer; l++) ker_q[k][l] <= kernel[k][l];
          for (int unsigned i = 0; i < OUT_SIZE; i++)
            for (int unsigned j = 0; j < OUT_SIZE; j++) acc[i][j] <= '0;
          r    <= '0;
          c    <= '0;
          busy <= 1'b1;
        end
        ACCUM: begin
          // Scatter expressed as a full (i,j,k,l) sweep so every index is static;
          // for a given (r,c) at most one (k,l) hits each accumulator.
          for (int unsigned i = 0; i < OUT_SIZE; i++)
            for (int unsigned j = 0; j < OUT_SIZE; j++)
              for (int unsigned k = 0; k < SIZEKer; k++)
                for (int unsigned l = 0; l < SIZEKer; l++)
                  if ((32'(r) + k == i) && (32'(c) + l == j))
                    acc[i][j] <= acc[i][j] + AW'(prod[k][l]);
          if (c == LAST) begin
            c <= '0;
            r <= (r == LAST) ? '0 : r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        FINAL: begin
          for (int unsigned i = 0; i < OUT_SIZE; i++)
            for (int unsigned j = 0; j < OUT_SIZE; j++)
              deconvOut[i][j] <= sat(acc[i][j]);
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deconv2.sv
// Randomised/directed bench for deconv2: default instance plus a SHIFT=2 instance
// sharing stimulus, both checked against a gather-form arithmetic model.
module tb_deconv2;
  localparam int IN   = 6;
  localparam int K    = 3;
  localparam int OUT  = IN + K - 1;
  localparam int W    = 8;
  localparam int MAPW = OUT*OUT*W;
  localparam int LAT  = IN*IN;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic start = 1'b0;
  logic signed [IN-1:0][IN-1:0][W-1:0]   inpMatrixI = '0;
  logic signed [K-1:0][K-1:0][W-1:0]     kernel = '0;
  logic busy, done, busy_s, done_s;
  logic signed [OUT-1:0][OUT-1:0][W-1:0] deconvOut, deconvOut_s;

  int in_m [IN][IN];
  int ker_m [K][K];
  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  deconv2 dut (.clock(clock), .nreset(nreset), .start(start), .inpMatrixI(inpMatrixI),
               .kernel(kernel), .busy(busy), .done(done), .deconvOut(deconvOut));
  deconv2 #(.SHIFT(2)) dut_s (.clock(clock), .nreset(nreset), .start(start),
               .inpMatrixI(inpMatrixI), .kernel(kernel), .busy(busy_s), .done(done_s),
               .deconvOut(deconvOut_s));

  task automatic chk(input string tag, input logic [MAPW-1:0] obs, input logic [MAPW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // out[i][j] = sum over input pixels whose kernel footprint covers (i,j)
  function automatic logic [MAPW-1:0] model(input int shift);
    logic [MAPW-1:0] res;
    longint acc;
    int v;
    res = '0;
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < OUT; j++) begin
        acc = 0;
        for (int y = 0; y < IN; y++)
          for (int x = 0; x < IN; x++)
            if (i - y >= 0 && i - y < K && j - x >= 0 && j - x < K)
              acc += longint'(in_m[y][x]) * longint'(ker_m[i-y][j-x]);
        v = int'(acc >>> shift);
`ifdef DECONV_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        res[(i*OUT+j)*W +: W] = W'(v);
      end
    return res;
  endfunction

  task automatic drive();
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++) inpMatrixI[i][j] = W'(in_m[i][j]);
    for (int k = 0; k < K; k++)
      for (int l = 0; l < K; l++) kernel[k][l] = W'(ker_m[k][l]);
  endtask

  task automatic scramble();
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++) inpMatrixI[i][j] = W'($urandom);
    for (int k = 0; k < K; k++)
      for (int l = 0; l < K; l++) kernel[k][l] = W'($urandom);
  endtask

  task automatic fill(input int iv, input int kv);
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++) in_m[i][j] = iv;
    for (int k = 0; k < K; k++)
      for (int l = 0; l < K; l++) ker_m[k][l] = kv;
  endtask

  task automatic rand_ops();
    logic [W-1:0] b;
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++) begin b = W'($urandom); in_m[i][j] = int'($signed(b)); end
    for (int k = 0; k < K; k++)
      for (int l = 0; l < K; l++) begin b = W'($urandom); ker_m[k][l] = int'($signed(b)); end
  endtask

  // prestarted: the accepting edge already happened (back-to-back); chain: hold start for the next job
  task automatic run_job(input string tag, input int pulse_at, input bit chain, input bit prestarted);
    logic [MAPW-1:0] e0, e2;
    bit early;
    e0 = model(0);
    e2 = model(2);
    if (!prestarted) begin
      drive();
      start = 1'b1;
      @(posedge clock); #1;
      chk({tag, "_busy_E0"}, busy, 1);
    end
    start = 1'b0;
    scramble();
    early = 1'b0;
    for (int n = 1; n <= LAT; n++) begin
      @(posedge clock); #1;
      if (done || done_s) early = 1'b1;
      start = (n == pulse_at - 1);
    end
    chk({tag, "_no_early_done"}, early, 0);
    chk({tag, "_busy_last_accum"}, busy, 1);
    if (chain) begin
      rand_ops();
      drive();
      start = 1'b1;
    end
    @(posedge clock); #1;
    chk({tag, "_done"}, {done, done_s}, 2'b11);
    chk({tag, "_busy_fall"}, {busy, busy_s}, 2'b00);
    chk({tag, "_map"}, deconvOut, e0);
    chk({tag, "_map_s2"}, deconvOut_s, e2);
    @(posedge clock); #1;
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_busy_next"}, busy, chain);
  endtask

  initial begin
    bit early;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {busy, busy_s}, 0);
    chk("rst_done", {done, done_s}, 0);
    chk("rst_map", deconvOut, 0);
    chk("rst_map_s2", deconvOut_s, 0);
    nreset = 1'b1;
    @(posedge clock); #1;
    chk("idle_busy", busy, 0);

    fill(0, 0);
    in_m[0][0] = 1;
    for (int k = 0; k < K; k++)
      for (int l = 0; l < K; l++) ker_m[k][l] = k*K + l + 1;
    run_job("impulse", 0, 0, 0);
    chk("imp_00", deconvOut[0][0], 1);
    chk("imp_11", deconvOut[1][1], 5);
    chk("imp_22", deconvOut[2][2], 9);
    chk("imp_33", deconvOut[3][3], 0);

    fill(1, 1);
    run_job("ones", 0, 0, 0);
    chk("ones_00", deconvOut[0][0], 1);
    chk("ones_02", deconvOut[0][2], 3);
    chk("ones_22", deconvOut[2][2], 9);
    chk("ones_44", deconvOut[4][4], 9);
    chk("ones_77", deconvOut[7][7], 1);
    chk("ones_07", deconvOut[0][7], 1);

    fill(100, 100);
    run_job("sat_pos", 0, 0, 0);
    chk("sat_pos_35", deconvOut[3][5], 8'd127);
    fill(100, -100);
    run_job("sat_neg", 0, 0, 0);
`ifdef DECONV_RELU_EN
    chk("sat_neg_35", deconvOut[3][5], 8'h00);
`else
    chk("sat_neg_35", deconvOut[3][5], 8'h80);
`endif

    fill(0, 0);
    in_m[0][0] = 1;
    ker_m[0][0] = 9;
    run_job("shift_pos", 0, 0, 0);
    chk("shift_pos_00", deconvOut_s[0][0], 8'd2);
    ker_m[0][0] = -9;
    run_job("shift_neg", 0, 0, 0);
`ifdef DECONV_RELU_EN
    chk("shift_neg_00", deconvOut_s[0][0], 8'h00);
`else
    chk("shift_neg_00", deconvOut_s[0][0], 8'hFD);
`endif

    rand_ops();
    run_job("ignored_start", 10, 0, 0);

    rand_ops();
    run_job("b2b_a", 0, 1, 0);
    run_job("b2b_b", 0, 0, 1);

    rand_ops();
    drive();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    nreset = 1'b0;
    #2;
    chk("mid_rst_busy", {busy, busy_s}, 0);
    chk("mid_rst_done", {done, done_s}, 0);
    chk("mid_rst_map", deconvOut, 0);
    chk("mid_rst_map_s2", deconvOut_s, 0);
    @(posedge clock); @(posedge clock); #1;
    nreset = 1'b1;
    early = 1'b0;
    for (int n = 0; n < LAT + 4; n++) begin
      @(posedge clock); #1;
      if (done || done_s || busy) early = 1'b1;
    end
    chk("mid_rst_no_done", early, 0);

    for (int t = 0; t < 4; t++) begin
      rand_ops();
      run_job($sformatf("rand%0d", t), 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
